// File: rtl/pix_proc_stream.sv
`default_nettype none
// ============================================================================
// pix_proc_stream : 3-stage valid/ready per-pixel colour processor with
//                   frame-start latched mode and binary threshold.
// Revision        : 1.0
// ============================================================================
module pix_proc_stream #(
   parameter int CW         = 8,
   parameter int THRESH_RST = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3*CW-1:0]   s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_user,
   input  logic              s_last,
   output logic [3*CW-1:0]   m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_user,
   output logic              m_last,
   input  logic [2:0]        mode,
   input  logic [CW-1:0]     thresh,
   output logic [2:0]        act_mode
);
   localparam int PW = 3*CW;
   localparam int SW = CW+8;

   localparam logic [2:0]    MODE_INV  = 3'd1;
   localparam logic [2:0]    MODE_GREY = 3'd2;
   localparam logic [2:0]    MODE_BIN  = 3'd3;
   localparam logic [2:0]    MODE_RED  = 3'd4;

   localparam logic [CW-1:0] THR_INIT = CW'(THRESH_RST);
   localparam logic [SW-1:0] W_R      = SW'(77);
   localparam logic [SW-1:0] W_G      = SW'(150);
   localparam logic [SW-1:0] W_B      = SW'(29);

   logic          rdy1, rdy2, rdy3, s_acc;
   logic [SW-1:0] sum;
   logic [CW-1:0] y2;
   logic          white2;
   logic [PW-1:0] res3;

   logic [2:0]    act_mode_q, act_mode_d;
   logic [CW-1:0] thr_q, thr_d;

   logic          v1_q, v1_d, user1_q, user1_d, last1_q, last1_d;
   logic [PW-1:0] pix1_q, pix1_d;
   logic [2:0]    mode1_q, mode1_d;
   logic [CW-1:0] thr1_q, thr1_d;

   logic          v2_q, v2_d, user2_q, user2_d, last2_q, last2_d;
   logic [PW-1:0] pix2_q, pix2_d;
   logic [SW-1:0] sum2_q, sum2_d;
   logic [2:0]    mode2_q, mode2_d;
   logic [CW-1:0] thr2_q, thr2_d;

   logic          v3_q, v3_d, user3_q, user3_d, last3_q, last3_d;
   logic [PW-1:0] data3_q, data3_d;

   // A stage can load when empty or when its content moves on this cycle.
   always_comb begin
      rdy3  = !v3_q || m_ready;
      rdy2  = !v2_q || rdy3;
      rdy1  = !v1_q || rdy2;
      s_acc = s_valid && rdy1;
   end

   always_comb begin
      sum = W_R * SW'(pix1_q[PW-1:2*CW])
          + W_G * SW'(pix1_q[2*CW-1:CW])
          + W_B * SW'(pix1_q[CW-1:0]);
   end

   // Y >= thr is equivalent to sum >= thr*256, which avoids a separate compare on Y.
   always_comb begin
      y2     = sum2_q[SW-1:8];
      white2 = (sum2_q >= {thr2_q, 8'h00});
      case (mode2_q)
         MODE_INV:  res3 = ~pix2_q;
         MODE_GREY: res3 = {y2, y2, y2};
         MODE_BIN:  res3 = {PW{white2}};
         MODE_RED:  res3 = {pix2_q[PW-1:2*CW], {(2*CW){1'b0}}};
         default:   res3 = pix2_q;
      endcase
   end

   always_comb begin
      act_mode_d = act_mode_q;
      thr_d      = thr_q;
      v1_d = v1_q; pix1_d = pix1_q; mode1_d = mode1_q; thr1_d = thr1_q;
      user1_d = user1_q; last1_d = last1_q;
      v2_d = v2_q; pix2_d = pix2_q; sum2_d = sum2_q; mode2_d = mode2_q; thr2_d = thr2_q;
      user2_d = user2_q; last2_d = last2_q;
      v3_d = v3_q; data3_d = data3_q; user3_d = user3_q; last3_d = last3_q;

      if (s_acc && s_user) begin
         act_mode_d = mode;
         thr_d      = thresh;
      end

      if (rdy1) v1_d = s_valid;
      if (s_acc) begin
         pix1_d  = s_data;
         mode1_d = s_user ? mode   : act_mode_q;
         thr1_d  = s_user ? thresh : thr_q;
         user1_d = s_user;
         last1_d = s_last;
      end

      if (rdy2) v2_d = v1_q;
      if (rdy2 && v1_q) begin
         pix2_d  = pix1_q;
         sum2_d  = sum;
         mode2_d = mode1_q;
         thr2_d  = thr1_q;
         user2_d = user1_q;
         last2_d = last1_q;
      end

      if (rdy3) v3_d = v2_q;
      if (rdy3 && v2_q) begin
         data3_d = res3;
         user3_d = user2_q;
         last3_d = last2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_mode_q <= 3'd0;
         thr_q      <= THR_INIT;
         v1_q <= 1'b0; pix1_q <= '0; mode1_q <= 3'd0; thr1_q <= '0;
         user1_q <= 1'b0; last1_q <= 1'b0;
         v2_q <= 1'b0; pix2_q <= '0; sum2_q <= '0; mode2_q <= 3'd0; thr2_q <= '0;
         user2_q <= 1'b0; last2_q <= 1'b0;
         v3_q <= 1'b0; data3_q <= '0; user3_q <= 1'b0; last3_q <= 1'b0;
      end else begin
         act_mode_q <= act_mode_d;
         thr_q      <= thr_d;
         v1_q <= v1_d; pix1_q <= pix1_d; mode1_q <= mode1_d; thr1_q <= thr1_d;
         user1_q <= user1_d; last1_q <= last1_d;
         v2_q <= v2_d; pix2_q <= pix2_d; sum2_q <= sum2_d; mode2_q <= mode2_d; thr2_q <= thr2_d;
         user2_q <= user2_d; last2_q <= last2_d;
         v3_q <= v3_d; data3_q <= data3_d; user3_q <= user3_d; last3_q <= last3_d;
      end
   end

   assign s_ready  = rdy1;
   assign m_valid  = v3_q;
   assign m_data   = data3_q;
   assign m_user   = user3_q;
   assign m_last   = last3_q;
   assign act_mode = act_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_pix_proc_stream.sv
`default_nettype none
// ============================================================================
// tb_pix_proc_stream : directed and random traffic scored against a
//                      queue-based reference of the colour processor.
// Revision           : 1.0
// ============================================================================
module tb_pix_proc_stream;
   localparam int CW = 8;
   localparam int PW = 3*CW;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] s_data;
   logic          s_valid, s_user, s_last, m_ready;
   logic [2:0]    mode;
   logic [CW-1:0] thresh;
   logic          s_ready, m_valid, m_user, m_last;
   logic [PW-1:0] m_data;
   logic [2:0]    act_mode;

   typedef struct packed {
      logic [PW-1:0] data;
      logic          user;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   logic [2:0]    mode_m;
   logic [CW-1:0] thr_m;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic          hold_pend = 1'b0;
   logic [PW+1:0] hold_val;

   pix_proc_stream #(.CW(CW), .THRESH_RST(128)) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_user(s_user), .s_last(s_last),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_user(m_user), .m_last(m_last),
      .mode(mode), .thresh(thresh), .act_mode(act_mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference pixel operation straight from the luma/mode rules.
   function automatic logic [PW-1:0] ref_pix(input logic [PW-1:0] p, input logic [2:0] md,
                                             input logic [CW-1:0] th);
      int r, g, b, y;
      logic [CW-1:0] y8;
      r  = int'(p[3*CW-1:2*CW]);
      g  = int'(p[2*CW-1:CW]);
      b  = int'(p[CW-1:0]);
      y  = (77*r + 150*g + 29*b) / 256;
      y8 = CW'(y);
      case (md)
         3'd1:    return ~p;
         3'd2:    return {y8, y8, y8};
         3'd3:    return (y >= int'(th)) ? {PW{1'b1}} : {PW{1'b0}};
         3'd4:    return {p[3*CW-1:2*CW], {(2*CW){1'b0}}};
         default: return p;
      endcase
   endfunction

   // One clock: called just after a negedge with inputs already driven.
   task automatic step(output bit acc);
      beat_t e;
      acc = 1'b0;
      #1;
      if (!rst) begin
         check("act_mode", 32'(act_mode), 32'(mode_m));
         check("s_ready", 32'(s_ready), 32'((exp_q.size() < 3) || m_ready));
         if (hold_pend) check("hold", 32'({m_data, m_user, m_last}), 32'(hold_val));
         hold_pend = m_valid && !m_ready;
         hold_val  = {m_data, m_user, m_last};
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious", 32'(m_valid), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("m_data", 32'(m_data), 32'(e.data));
               check("m_user", 32'(m_user), 32'(e.user));
               check("m_last", 32'(m_last), 32'(e.last));
            end
         end
         if (s_valid && s_ready) begin
            acc = 1'b1;
            if (s_user) begin
               mode_m = mode;
               thr_m  = thresh;
            end
            e.data = ref_pix(s_data, mode_m, thr_m);
            e.user = s_user;
            e.last = s_last;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         mode_m    = 3'd0;
         thr_m     = CW'(128);
         hold_pend = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [PW-1:0] px, input logic u, input logic l,
                       input logic [2:0] md, input logic [CW-1:0] th);
      bit acc = 1'b0;
      s_valid = 1'b1; s_data = px; s_user = u; s_last = l; mode = md; thresh = th;
      for (int i = 0; i < 32 && !acc; i++) step(acc);
      check("send_accept", 32'(acc), 32'(1));
      s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(acc);
      step(acc);
      check("drain", 32'(exp_q.size()), 32'(0));
   endtask

   // Single beat with no backpressure: m_valid must rise exactly 3 cycles later.
   task automatic one_beat(input string tag, input logic [2:0] md, input logic [CW-1:0] th,
                           input logic [PW-1:0] px, input logic [PW-1:0] exp_px);
      bit acc;
      m_ready = 1'b1;
      send(px, 1'b1, 1'b1, md, th);
      for (int n = 1; n <= 3; n++) begin
         check({tag, "_lat"}, 32'(m_valid), 32'(n == 3));
         if (n == 3) begin
            check(tag, 32'(m_data), 32'(exp_px));
            check({tag, "_user"}, 32'(m_user), 32'(1));
         end
         step(acc);
      end
   endtask

   initial begin
      bit acc;
      int idx, cyc, n;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0;
      m_ready = 1'b0; mode = 3'd0; thresh = '0;
      mode_m = 3'd0; thr_m = CW'(128);
      @(negedge clk);
      step(acc);
      step(acc);
      rst = 1'b0;
      check("rst_m_valid", 32'(m_valid), 32'(0));
      check("rst_m_data", 32'(m_data), 32'(0));
      check("rst_m_user", 32'(m_user), 32'(0));
      check("rst_m_last", 32'(m_last), 32'(0));
      check("rst_act_mode", 32'(act_mode), 32'(0));
      check("rst_s_ready", 32'(s_ready), 32'(1));

      one_beat("pass",   3'd0, 8'd128, 24'hC86432, 24'hC86432);
      one_beat("invert", 3'd1, 8'd128, 24'hC86432, 24'h379BCD);
      one_beat("grey",   3'd2, 8'd128, 24'hC86432, 24'h7C7C7C);
      one_beat("bin128", 3'd3, 8'd128, 24'hC86432, 24'h000000);
      one_beat("bin124", 3'd3, 8'd124, 24'hC86432, 24'hFFFFFF);
      one_beat("bin125", 3'd3, 8'd125, 24'hC86432, 24'h000000);
      one_beat("red",    3'd4, 8'd0,   24'hC86432, 24'hC80000);
      one_beat("rsvd6",  3'd6, 8'd0,   24'hC86432, 24'hC86432);
      drain();

      // Backpressure burst of 10 pixels, output stalled for cycles 2..8.
      idx = 1; cyc = 0;
      while (idx <= 10 && cyc < 60) begin
         s_valid = 1'b1; s_data = PW'(idx); s_user = (idx == 1); s_last = (idx == 10);
         mode = 3'd0; thresh = 8'd0;
         m_ready = !(cyc >= 2 && cyc <= 8);
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      check("bp_all_sent", 32'(idx), 32'(11));
      drain();

      // Mode request changes mid-frame must not take effect until next frame start.
      m_ready = 1'b1;
      send(24'h102030, 1'b1, 1'b0, 3'd1, 8'd0);
      send(24'h405060, 1'b0, 1'b0, 3'd1, 8'd0);
      send(24'h708090, 1'b0, 1'b0, 3'd2, 8'd0);
      send(24'hA0B0C0, 1'b0, 1'b1, 3'd2, 8'd0);
      check("mid_act_mode", 32'(act_mode), 32'(1));
      send(24'hC86432, 1'b1, 1'b0, 3'd2, 8'd0);
      send(24'h112233, 1'b0, 1'b1, 3'd0, 8'd0);
      drain();
      check("new_frame_act_mode", 32'(act_mode), 32'(2));

      // Reset with three beats in flight.
      m_ready = 1'b0;
      send(24'h111111, 1'b1, 1'b0, 3'd3, 8'd50);
      send(24'h222222, 1'b0, 1'b0, 3'd3, 8'd50);
      send(24'h333333, 1'b0, 1'b0, 3'd3, 8'd50);
      rst = 1'b1;
      step(acc);
      rst = 1'b0;
      check("midrst_m_valid", 32'(m_valid), 32'(0));
      check("midrst_act_mode", 32'(act_mode), 32'(0));
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) step(acc);

      // Random soak.
      n = 0; cyc = 0;
      while (n < 10000 && cyc < 60000) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = PW'($urandom);
         s_user  = ($urandom_range(0, 63) == 0);
         s_last  = ($urandom_range(0, 15) == 0);
         mode    = 3'($urandom_range(0, 7));
         thresh  = CW'($urandom);
         m_ready = 1'($urandom_range(0, 1));
         step(acc);
         if (acc) n++;
         cyc++;
      end
      check("soak_count", 32'(n), 32'(10000));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
